page_bl_d1_row_serialize8: RTL and testbench

- Downstream consumer of the eight 9-bit per-column token streams s..z produced by the block-level queue page in the JPEG decode pipeline.
- Takes one token from each stream in fixed order s,t,u,v,w,x,y,z and emits them on a single serial stream: one 8-token row per lap.
- Collapses the eight aligned end-of-stream tokens into one downstream end-of-stream token.
- Uses the codebase's valid/back-pressure stream protocol: data d, end-of-stream flag e, valid v, back-pressure b.

---
 rtl/page_bl_d1_row_serialize8.sv | 148 ++++++++++++++
 tb/tb_page_bl_d1_row_serialize8.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/page_bl_d1_row_serialize8.sv
// Serializes eight per-column token streams (s..z) into one row-ordered stream and
// collapses the aligned end-of-stream tokens. Optional checks/counters: SER8_EOSCHK_EN.
module page_bl_d1_row_serialize8 #(
    parameter int WIDTH = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] s_d, t_d, u_d, v_d, w_d, x_d, y_d, z_d,
    input  logic             s_e, t_e, u_e, v_e, w_e, x_e, y_e, z_e,
    input  logic             s_v, t_v, u_v, v_v, w_v, x_v, y_v, z_v,
    output logic             s_b, t_b, u_b, v_b, w_b, x_b, y_b, z_b,
    output logic [WIDTH-1:0] o_d,
    output logic             o_e,
    output logic             o_v,
    input  logic             o_b,
    output logic [15:0]      rows,
    output logic             err
);

    // state    | meaning
    // RUN      | forwarding data tokens, sel walks s..z
    // EOSDRAIN | s delivered EOS; swallowing t..z EOS tokens
    // EOSOUT   | waiting for the output register to take the single EOS token
    // DONE     | stream finished; all inputs stalled until reset
    typedef enum logic [1:0] {RUN, EOSDRAIN, EOSOUT, DONE} state_t;

    state_t           state, state_nxt;
    logic [2:0]       sel, sel_nxt;
    logic [WIDTH-1:0] in_d [8];
    logic [7:0]       in_e, in_v, in_b;
    logic [WIDTH-1:0] cur_d;
    logic             cur_e, cur_v;
    logic             load, acc, fwd, eos_emit;

    assign in_d[0] = s_d; assign in_d[1] = t_d; assign in_d[2] = u_d; assign in_d[3] = v_d;
    assign in_d[4] = w_d; assign in_d[5] = x_d; assign in_d[6] = y_d; assign in_d[7] = z_d;
    assign in_e = {z_e, y_e, x_e, w_e, v_e, u_e, t_e, s_e};
    assign in_v = {z_v, y_v, x_v, w_v, v_v, u_v, t_v, s_v};
    assign {z_b, y_b, x_b, w_b, v_b, u_b, t_b, s_b} = in_b;

    assign cur_d = in_d[sel];
    assign cur_e = in_e[sel];
    assign cur_v = in_v[sel];
    assign load  = !o_v || !o_b;
    assign acc   = cur_v && !in_b[sel];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            sel   <= 3'd0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        fwd       = 1'b0;
        eos_emit  = 1'b0;
        case (state)
            RUN: begin
                if (acc) begin
                    if (cur_e && sel == 3'd0) begin
                        state_nxt = EOSDRAIN;
                        sel_nxt   = 3'd1;
                    end else begin
                        fwd     = 1'b1;
                        sel_nxt = sel + 3'd1;
                    end
                end
            end
            EOSDRAIN: begin
                if (acc) begin
                    sel_nxt = sel + 3'd1;
                    if (sel == 3'd7) state_nxt = EOSOUT;
                end
            end
            EOSOUT: begin
                if (load) begin
                    eos_emit  = 1'b1;
                    state_nxt = DONE;
                end
            end
            default: ;
        endcase
    end

    // Back-pressure is held high on every channel while reset is asserted.
    always_comb begin
        in_b = 8'hFF;
        if (reset) begin
            case (state)
                RUN:      in_b[sel] = !load;
                EOSDRAIN: in_b[sel] = 1'b0;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            o_d <= '0;
            o_e <= 1'b0;
            o_v <= 1'b0;
        end else if (load) begin
            if (fwd) begin
                o_d <= cur_d;
                o_e <= 1'b0;
                o_v <= 1'b1;
            end else if (eos_emit) begin
                o_d <= '0;
                o_e <= 1'b1;
                o_v <= 1'b1;
            end else begin
                o_v <= 1'b0;
            end
        end
    end

`ifdef SER8_EOSCHK_EN
    logic        row_inc, err_set;
    logic [15:0] rows_q;
    logic        err_q;

    assign row_inc = fwd && sel == 3'd7;
    assign err_set = acc && ((state == RUN && cur_e && sel != 3'd0) ||
                             (state == EOSDRAIN && !cur_e));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rows_q <= 16'd0;
            err_q  <= 1'b0;
        end else begin
            if (row_inc) rows_q <= rows_q + 16'd1;
            if (err_set) err_q  <= 1'b1;
        end
    end

    assign rows = rows_q;
    assign err  = err_q;
`else
    assign rows = 16'd0;
    assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_page_bl_d1_row_serialize8.sv
// Directed bench for page_bl_d1_row_serialize8: row order, stalls, idle channels,
// misaligned EOS, async reset mid-row and EOS collapse.
module tb_page_bl_d1_row_serialize8;

`ifdef SER8_EOSCHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [8:0]  d_in [8];
    logic [7:0]  e_in = 8'h00;
    logic [7:0]  v_in = 8'h00;
    wire  [7:0]  b_out;
    logic [8:0]  o_d;
    logic        o_e, o_v;
    logic        o_b = 1'b0;
    logic [15:0] rows;
    logic        err;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clock = ~clock;

    page_bl_d1_row_serialize8 #(.WIDTH(9)) dut (
        .clock(clock), .reset(reset),
        .s_d(d_in[0]), .t_d(d_in[1]), .u_d(d_in[2]), .v_d(d_in[3]),
        .w_d(d_in[4]), .x_d(d_in[5]), .y_d(d_in[6]), .z_d(d_in[7]),
        .s_e(e_in[0]), .t_e(e_in[1]), .u_e(e_in[2]), .v_e(e_in[3]),
        .w_e(e_in[4]), .x_e(e_in[5]), .y_e(e_in[6]), .z_e(e_in[7]),
        .s_v(v_in[0]), .t_v(v_in[1]), .u_v(v_in[2]), .v_v(v_in[3]),
        .w_v(v_in[4]), .x_v(v_in[5]), .y_v(v_in[6]), .z_v(v_in[7]),
        .s_b(b_out[0]), .t_b(b_out[1]), .u_b(b_out[2]), .v_b(b_out[3]),
        .w_b(b_out[4]), .x_b(b_out[5]), .y_b(b_out[6]), .z_b(b_out[7]),
        .o_d(o_d), .o_e(o_e), .o_v(o_v), .o_b(o_b),
        .rows(rows), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: tokens seen accepted just before the edge are retired by the source.
    task automatic tick();
        logic [7:0] acc;
        #1;
        acc = v_in & ~b_out;
        @(posedge clock);
        #1;
        v_in = v_in & ~acc;
    endtask

    task automatic load_all(input logic [8:0] base);
        for (int k = 0; k < 8; k++) d_in[k] = base + 9'(k);
        e_in = 8'h00;
        v_in = 8'hFF;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 8; k++) d_in[k] = 9'd0;
        #1;
        chk("rst_ov", 32'(o_v), 0);
        chk("rst_b", 32'(b_out), 32'hFF);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("rst_rows", 32'(rows), 0);
        chk("rst_err", 32'(err), 0);

        // basic row
        load_all(9'h001);
        #1;
        chk("row1_b0", 32'(b_out), 32'hFE);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("row1_d%0d", k), 32'(o_d), 32'(k + 1));
            chk($sformatf("row1_v%0d", k), 32'(o_v), 1);
        end
        #1;
        chk("row1_rows", 32'(rows), CHK_EN ? 1 : 0);
        chk("row1_sel0", 32'(b_out), 32'hFE);
        tick();
        chk("row1_drain", 32'(o_v), 0);

        // downstream stall
        load_all(9'h001);
        tick();
        chk("stall_d0", 32'(o_d), 1);
        o_b = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_tb", 32'(b_out[1]), 1);
            tick();
            chk("stall_ov", 32'(o_v), 1);
            chk("stall_od", 32'(o_d), 1);
        end
        o_b = 1'b0;
        #1;
        chk("stall_rel_tb", 32'(b_out[1]), 0);
        for (int k = 1; k < 8; k++) begin
            tick();
            chk($sformatf("stall_d%0d", k), 32'(o_d), 32'(k + 1));
        end
        chk("stall_rows", 32'(rows), CHK_EN ? 2 : 0);
        tick();
        chk("stall_drain", 32'(o_v), 0);

        // idle upstream channels
        d_in[2] = 9'h033; v_in[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("idle_ub", 32'(b_out[2]), 1);
            tick();
            chk("idle_ov", 32'(o_v), 0);
        end
        d_in[0] = 9'h031; v_in[0] = 1'b1;
        tick();
        chk("idle_s", 32'(o_d), 32'h31);
        d_in[1] = 9'h032; v_in[1] = 1'b1;
        tick();
        chk("idle_t", 32'(o_d), 32'h32);
        #1;
        chk("idle_ub_open", 32'(b_out[2]), 0);
        tick();
        chk("idle_u", 32'(o_d), 32'h33);
        for (int k = 3; k < 8; k++) d_in[k] = 9'h031 + 9'(k);
        v_in[7:3] = 5'h1F;
        repeat (5) tick();
        chk("idle_z", 32'(o_d), 32'h38);
        chk("idle_rows", 32'(rows), CHK_EN ? 3 : 0);
        tick();

        // misaligned end-of-stream on t
        d_in[0] = 9'h010; e_in = 8'h00; v_in = 8'h01;
        tick();
        chk("mis_s", 32'(o_d), 32'h10);
        d_in[1] = 9'h020; e_in[1] = 1'b1; v_in[1] = 1'b1;
        tick();
        chk("mis_td", 32'(o_d), 32'h20);
        chk("mis_te", 32'(o_e), 0);
        chk("mis_tv", 32'(o_v), 1);
        chk("mis_err", 32'(err), CHK_EN ? 1 : 0);
        e_in = 8'h00;
        tick();
        tick();
        chk("mis_err_sticky", 32'(err), CHK_EN ? 1 : 0);

        // async reset mid-row
        pulse_reset();
        chk("clr_err", 32'(err), 0);
        load_all(9'h041);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("mid_d%0d", k), 32'(o_d), 32'h41 + 32'(k));
        end
        #2;
        reset = 1'b0;
        #1;
        chk("mid_ov", 32'(o_v), 0);
        chk("mid_rows", 32'(rows), 0);
        chk("mid_b", 32'(b_out), 32'hFF);
        @(negedge clock);
        reset = 1'b1;
        d_in[0] = 9'h051; v_in[0] = 1'b1;
        @(posedge clock);
        #1;
        tick();
        chk("mid_restart_s", 32'(o_d), 32'h51);
        v_in = 8'h00;
        pulse_reset();

        // aligned end-of-stream collapse
        for (int k = 0; k < 8; k++) d_in[k] = 9'h1FF;
        e_in = 8'hFF;
        v_in = 8'hFF;
        tick();
        chk("eos_s_ov", 32'(o_v), 0);
        for (int k = 1; k < 8; k++) begin
            tick();
            chk($sformatf("eos_drain%0d", k), 32'(o_v), 0);
        end
        chk("eos_consumed", 32'(v_in), 0);
        tick();
        chk("eos_ov", 32'(o_v), 1);
        chk("eos_oe", 32'(o_e), 1);
        chk("eos_od", 32'(o_d), 0);
        e_in = 8'h00;
        v_in = 8'hFF;
        #1;
        chk("done_b", 32'(b_out), 32'hFF);
        tick();
        chk("done_drain", 32'(o_v), 0);
        chk("done_b2", 32'(b_out), 32'hFF);
        chk("done_hold", 32'(v_in), 32'hFF);
        chk("done_err", 32'(err), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
